pipe_addsub: RTL and testbench



---
 rtl/pipe_addsub.sv | 152 +++++++++++++++
 tb/tb_pipe_addsub.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined ripple-carry adder/subtractor, one CHUNK per stage.
// Ports: clk, rst_n (async low); in_valid/in_ready, a, b, cin, sub in;
// out_valid/out_ready, sum, cout, ovf out; sat in with PIPE_ADDSUB_SAT_EN.
module pipe_addsub #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
`ifdef PIPE_ADDSUB_SAT_EN
   input  logic             sat,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CHUNK = WIDTH / STAGES;
   localparam int LAST  = STAGES - 1;

   logic             v_q [STAGES];
   logic             v_d [STAGES];
   logic [WIDTH-1:0] a_q [STAGES];
   logic [WIDTH-1:0] a_d [STAGES];
   logic [WIDTH-1:0] b_q [STAGES];
   logic [WIDTH-1:0] b_d [STAGES];
   logic [WIDTH-1:0] s_q [STAGES];
   logic [WIDTH-1:0] s_d [STAGES];
   logic             c_q [STAGES];
   logic             c_d [STAGES];
`ifdef PIPE_ADDSUB_SAT_EN
   logic             sat_q [STAGES];
   logic             sat_d [STAGES];
`endif
   logic             ovf_q;
   logic             ovf_d;
   logic             stall;

   // Whole pipeline freezes only when a finished result is refused.
   assign stall    = v_q[LAST] && !out_ready;
   assign in_ready = !stall;

   always_comb begin : stage_logic
      logic             vi;
      logic             ci;
      logic             c;
      logic             cm;
      logic [WIDTH-1:0] ai;
      logic [WIDTH-1:0] bi;
      logic [WIDTH-1:0] s;
`ifdef PIPE_ADDSUB_SAT_EN
      logic             sti;
`endif
      int               idx;
      ovf_d = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         if (k == 0) begin
            vi = in_valid;
            ai = a;
            // Subtract as A + ~B + ~borrow.
            bi = sub ? ~b : b;
            ci = sub ? ~cin : cin;
            s  = '0;
`ifdef PIPE_ADDSUB_SAT_EN
            sti = sat;
`endif
         end else begin
            vi = v_q[k-1];
            ai = a_q[k-1];
            bi = b_q[k-1];
            ci = c_q[k-1];
            s  = s_q[k-1];
`ifdef PIPE_ADDSUB_SAT_EN
            sti = sat_q[k-1];
`endif
         end
         c  = ci;
         cm = ci;
         for (int i = 0; i < CHUNK; i++) begin
            idx    = k * CHUNK + i;
            cm     = c;
            s[idx] = ai[idx] ^ bi[idx] ^ c;
            c      = (ai[idx] & bi[idx]) | (c & (ai[idx] ^ bi[idx]));
         end
         v_d[k] = vi;
         a_d[k] = ai;
         b_d[k] = bi;
         s_d[k] = s;
         c_d[k] = c;
`ifdef PIPE_ADDSUB_SAT_EN
         sat_d[k] = sti;
`endif
         // Last chunk holds the MSB: cm is carry into it, c out of it.
         if (k == LAST) ovf_d = cm ^ c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k] <= 1'b0;
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
            c_q[k] <= 1'b0;
`ifdef PIPE_ADDSUB_SAT_EN
            sat_q[k] <= 1'b0;
`endif
         end
         ovf_q <= 1'b0;
      end else if (!stall) begin
         v_q   <= v_d;
         a_q   <= a_d;
         b_q   <= b_d;
         s_q   <= s_d;
         c_q   <= c_d;
`ifdef PIPE_ADDSUB_SAT_EN
         sat_q <= sat_d;
`endif
         ovf_q <= ovf_d;
      end
   end

   assign out_valid = v_q[LAST];
   assign cout      = c_q[LAST];
   assign ovf       = ovf_q;

`ifdef PIPE_ADDSUB_SAT_EN
   // Clamp toward the true sign, which is the inverse of the wrapped MSB.
   always_comb begin
      sum = s_q[LAST];
      if (sat_q[LAST] && ovf_q) begin
         sum = {~s_q[LAST][WIDTH-1], {(WIDTH-1){s_q[LAST][WIDTH-1]}}};
      end
   end
`else
   assign sum = s_q[LAST];
`endif

   // Operand copies leaving the last stage are not needed downstream.
   logic unused_ops;
   assign unused_ops = ^{a_q[LAST], b_q[LAST]};

endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub: directed and streaming checks of pipe_addsub
// (WIDTH=16, STAGES=4), immediate assertions, single summary line.
module tb_pipe_addsub;

   localparam int W = 16;
   localparam int S = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          cin = 1'b0;
   logic          sub = 1'b0;
   logic          sat = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  sum;
   logic          cout;
   logic          ovf;

   int n_cmp = 0;
   int n_bad = 0;

   logic [17:0] q[$];
   logic [17:0] held;
   logic [17:0] e;
   logic        stalled;
   int          sent;
   int          cyc;

   always #5 clk = ~clk;

   pipe_addsub #(.WIDTH(W), .STAGES(S)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .a(a),
      .b(b),
      .cin(cin),
      .sub(sub),
`ifdef PIPE_ADDSUB_SAT_EN
      .sat(sat),
`endif
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum(sum),
      .cout(cout),
      .ovf(ovf)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Reference result as {ovf, cout, sum}, from plain 17-bit arithmetic.
   function automatic logic [17:0] model(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic ci, input logic sb);
      logic [W:0]   t;
      logic [W-1:0] yy;
      logic         o;
      yy = sb ? ~y : y;
      t  = {1'b0, x} + {1'b0, yy} + {16'd0, (sb ? ~ci : ci)};
      o  = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
      return {o, t[W], t[W-1:0]};
   endfunction

   task automatic one(input string tag, input logic [W-1:0] x,
                      input logic [W-1:0] y, input logic ci,
                      input logic sb, input logic st,
                      input logic [W-1:0] es, input logic ec,
                      input logic eo);
      out_ready = 1'b1;
      a = x; b = y; cin = ci; sub = sb; sat = st;
      in_valid = 1'b1;
      #1;
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      step;
      in_valid = 1'b0;
      for (int i = 0; i < S - 1; i++) begin
         chk({tag, "_early_valid"}, 32'(out_valid), 32'd0);
         step;
      end
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_sum"}, 32'(sum), 32'(es));
      chk({tag, "_cout"}, 32'(cout), 32'(ec));
      chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
      step;
      chk({tag, "_drain"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      step;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      step;

      one("add", 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
      one("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      one("povf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      one("sub", 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
      one("subb", 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, 16'hFFFD, 1'b0, 1'b0);
      one("novf", 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
`ifdef PIPE_ADDSUB_SAT_EN
      one("satp", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1);
      one("satn", 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1);
`endif

      // Streaming with random back-pressure.
      sent = 0;
      stalled = 1'b0;
      held = '0;
      cyc = 0;
      while ((sent < 20 || q.size() != 0) && cyc < 400) begin
         if (stalled) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_hold", 32'({ovf, cout, sum}), 32'(held));
         end
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid = (sent < 20);
         a = W'($urandom);
         b = W'($urandom);
         cin = 1'($urandom);
         sub = 1'($urandom);
         sat = 1'b0;
         #1;
         chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("extra_out", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               chk("stream", 32'({ovf, cout, sum}), 32'(e));
            end
         end
         stalled = out_valid && !out_ready;
         held = {ovf, cout, sum};
         if (in_valid && in_ready) begin
            q.push_back(model(a, b, cin, sub));
            sent++;
         end
         step;
         cyc++;
      end
      in_valid = 1'b0;
      chk("stream_sent", 32'(sent), 32'd20);
      chk("stream_left", 32'(q.size()), 32'd0);

      // Reset with three beats in flight.
      out_ready = 1'b1;
      in_valid = 1'b1;
      sub = 1'b0;
      cin = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a = 16'h0100 + 16'(i);
         b = 16'h0011;
         step;
      end
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_valid", 32'(out_valid), 32'd0);
      chk("mrst_sum", 32'(sum), 32'd0);
      chk("mrst_cout", 32'(cout), 32'd0);
      chk("mrst_ovf", 32'(ovf), 32'd0);
      chk("mrst_in_ready", 32'(in_ready), 32'd1);
      step;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step;
         chk("mrst_quiet", 32'(out_valid), 32'd0);
      end
      one("post", 16'h00F0, 16'h0F0F, 1'b1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
